clk_divider: RTL and testbench
==============================

CLK_DIVIDER -- requirements
Module: clk_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter and divisor width in bits (legal 2..16).
REQ-002 SHALL have parameter DEFAULT_DIV, default 1, meaning half-period in initial_clk cycles loaded at reset (must fit WIDTH bits).
REQ-003 SHALL have port initial_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port div_valid  input  1  new-divisor request.
REQ-007 SHALL have port div_value  input  WIDTH  requested half-period in cycles.
REQ-008 SHALL have port div_ready  output  1  new divisor may be accepted.
REQ-009 SHALL have port clk  output  1  divided clock, registered.
REQ-010 SHALL have port tick  output  1  one-cycle pulse per clk edge (present only under REQ-026).

Function
REQ-011 SHALL hold an active divisor div_q and a counter cnt, both WIDTH bits; effective divisor = max(div_q, 1), so 0 behaves as 1.
REQ-012 With en=1 and cnt < effective-1, SHALL increment cnt and hold clk.
REQ-013 With en=1 and cnt >= effective-1 (wrap), SHALL clear cnt and invert clk in the same edge.
REQ-014 With en=0, SHALL hold cnt, clk and div_q; tick=0; no wrap occurs.
REQ-015 clk output period SHALL be 2*effective initial_clk cycles, 50% duty, no glitches (toggle-only register).
REQ-016 Reload FSM SHALL have states IDLE and PENDING; div_ready = (state==IDLE), driven from state register only.
REQ-017 In IDLE, div_valid=1 SHALL accept div_value into pending register pend_q and move to PENDING at that edge.
REQ-018 In PENDING, div_valid SHALL be ignored and pend_q held.
REQ-019 In PENDING, at the next wrap edge (REQ-013) SHALL load div_q <= pend_q and return to IDLE; the half-period ending at that wrap uses the old divisor.
REQ-020 Acceptance and wrap on the same edge: wrap uses old div_q; pend_q applies at the following wrap.
REQ-021 With en=0 in PENDING, SHALL remain PENDING until a wrap occurs after en returns to 1.
REQ-022 Loading a divisor smaller than current cnt SHALL be safe since cnt is 0 when div_q changes.

Reset
REQ-023 On rst=1 at a rising edge SHALL set clk=0, cnt=0, div_q=DEFAULT_DIV, pend_q=0, state=IDLE (div_ready=1), tick=0.
REQ-024 rst SHALL dominate en and div_valid; a request presented with rst=1 is discarded, mid-operation pending load is lost.
REQ-025 First clk edge after reset release SHALL occur on the effective-th enabled edge.

Configuration
REQ-026 Macro CLK_DIVIDER_TICK_EN defined: tick port exists, registered, high for exactly the one cycle following each wrap edge (same cycle clk shows new value), reset 0, 0 while en=0.
REQ-027 Macro CLK_DIVIDER_TICK_EN undefined: tick port and its register absent; all other behaviour identical.

Structure
REQ-028 Package clk_divider_pkg SHALL hold the reload-state typedef (IDLE, PENDING) and the DEFAULT_WIDTH=8 / DEFAULT_DIV=1 constants.
REQ-029 Block SHALL be a single module, no sub-modules; counter, reload FSM and output register in clk_divider.

Verification
REQ-030 DEFAULT_DIV=3, en=1 after reset -> clk rises at enabled edge 3, falls at 6, period 6 cycles, sustained 20 periods.
REQ-031 div_value=0 accepted -> after next wrap clk toggles every cycle (period 2), div_ready back to 1 the cycle after that wrap.
REQ-032 DEFAULT_DIV=3, accept div_value=5 at cnt=1 -> current half-period still ends at 3 cycles, subsequent half-periods 5; div_ready=0 from acceptance edge until load edge; second div_valid during PENDING ignored.
REQ-033 en=0 for 4 cycles at cnt=1, DEFAULT_DIV=4 -> clk, cnt frozen; after en=1 toggle occurs 3 enabled cycles later (total 4 enabled).
REQ-034 rst=1 for 1 cycle while PENDING with clk=1 -> clk=0, cnt=0, div_q=DEFAULT_DIV, div_ready=1, pending value never applied.
REQ-035 With CLK_DIVIDER_TICK_EN, DEFAULT_DIV=2 -> tick single-cycle pulses every 2 cycles, count of ticks equals count of clk edges over 100 cycles; without macro, build has no tick port.

Source files
------------

// File: rtl/clk_divider_pkg.sv
// Shared types and constants for the clk_divider block.
// The reload FSM state type and the build-time defaults live here so that
// any wrapper or bench can refer to the same names.
package clk_divider_pkg;

    // Reload FSM: IDLE accepts a new divisor, PENDING waits for the next wrap.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } reload_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 1;

    // A divisor of zero behaves as one; returns the wrap threshold (effective - 1).
    function automatic logic [15:0] wrap_limit(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage : clk_divider_pkg

// File: rtl/clk_divider.sv
// Programmable clock divider producing a registered 50% duty clock.
//
// The divided clock toggles every max(div_q,1) enabled cycles of initial_clk.
// A new half-period is requested with a div_valid/div_ready handshake; the
// request is parked and only applied on a wrap edge, so the half-period in
// flight always finishes with the divisor it started with and cnt is zero
// whenever div_q changes.
//
// Optional build macro: CLK_DIVIDER_TICK_EN adds the 'tick' output, a
// registered one-cycle pulse in the cycle after every wrap (the cycle in
// which clk shows its new level).
//
// Reload FSM states:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no request parked; div_ready=1, div_valid latches div_value
//   PENDING | pend_q holds a request; div_valid ignored, load at next wrap
module clk_divider #(
    parameter int WIDTH       = clk_divider_pkg::DEFAULT_WIDTH,
    parameter int DEFAULT_DIV = clk_divider_pkg::DEFAULT_DIV
) (
    input  logic             initial_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_value,
    output logic             div_ready,
    output logic             clk
`ifdef CLK_DIVIDER_TICK_EN
    ,
    output logic             tick
`endif
);

    import clk_divider_pkg::*;

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] limit;
    logic             wrap;
    reload_state_t    state;

    // Wrap threshold from the active divisor; zero is treated as one.
    always_comb begin
        limit = WIDTH'(wrap_limit(16'(div_q)));
        wrap  = en && (cnt >= limit);
    end

    // Half-period counter and toggle-only output register.
    always_ff @(posedge initial_clk) begin
        if (rst) begin
            cnt <= '0;
            clk <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt <= '0;
                clk <= ~clk;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

    // Reload FSM: park one request, apply it on the next wrap edge.
    always_ff @(posedge initial_clk) begin
        if (rst) begin
            state  <= IDLE;
            pend_q <= '0;
            div_q  <= RESET_DIV;
        end else begin
            case (state)
                IDLE: begin
                    if (div_valid) begin
                        pend_q <= div_value;
                        state  <= PENDING;
                    end
                end
                PENDING: begin
                    if (wrap) begin
                        div_q <= pend_q;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready comes straight from the state register so it never glitches.
    assign div_ready = (state == IDLE);

`ifdef CLK_DIVIDER_TICK_EN
    // One-cycle pulse aligned with the new clk level after each wrap.
    always_ff @(posedge initial_clk) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap;
        end
    end
`endif

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: three instances (DEFAULT_DIV 3, 4, 2)
// share one stimulus stream and are compared against a behavioural model.
module tb_clk_divider;

    logic       initial_clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       div_valid = 1'b0;
    logic [7:0] div_value = '0;
    logic [2:0] dclk;
    logic [2:0] drdy;
`ifdef CLK_DIVIDER_TICK_EN
    logic [2:0] dtick;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 initial_clk = ~initial_clk;

    clk_divider #(.WIDTH(8), .DEFAULT_DIV(3)) dut3 (
        .initial_clk(initial_clk), .rst(rst), .en(en), .div_valid(div_valid),
        .div_value(div_value), .div_ready(drdy[0]), .clk(dclk[0])
`ifdef CLK_DIVIDER_TICK_EN
        , .tick(dtick[0])
`endif
    );

    clk_divider #(.WIDTH(8), .DEFAULT_DIV(4)) dut4 (
        .initial_clk(initial_clk), .rst(rst), .en(en), .div_valid(div_valid),
        .div_value(div_value), .div_ready(drdy[1]), .clk(dclk[1])
`ifdef CLK_DIVIDER_TICK_EN
        , .tick(dtick[1])
`endif
    );

    clk_divider #(.WIDTH(8), .DEFAULT_DIV(2)) dut2 (
        .initial_clk(initial_clk), .rst(rst), .en(en), .div_valid(div_valid),
        .div_value(div_value), .div_ready(drdy[2]), .clk(dclk[2])
`ifdef CLK_DIVIDER_TICK_EN
        , .tick(dtick[2])
`endif
    );

    // Behavioural model: per instance, enabled cycles elapsed in the current
    // half-period, the active half-period, and at most one parked request.
    int defs [3] = '{3, 4, 2};
    bit m_clk [3] = '{0, 0, 0};
    bit m_tick [3] = '{0, 0, 0};
    int m_elapsed [3] = '{0, 0, 0};
    int m_half [3] = '{3, 4, 2};
    int m_pend [3] = '{0, 0, 0};
    bit m_parked [3] = '{0, 0, 0};

    task automatic check(input string name, input int idx, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit v, input int val);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_clk[i] = 0; m_tick[i] = 0; m_elapsed[i] = 0;
                m_half[i] = defs[i]; m_pend[i] = 0; m_parked[i] = 0;
            end else begin
                int eff;
                bit toggles;
                eff = (m_half[i] < 1) ? 1 : m_half[i];
                toggles = e && (m_elapsed[i] + 1 >= eff);
                if (e) begin
                    if (toggles) begin
                        m_elapsed[i] = 0;
                        m_clk[i] = !m_clk[i];
                    end else begin
                        m_elapsed[i]++;
                    end
                end
                if (m_parked[i]) begin
                    if (toggles) begin
                        m_half[i] = m_pend[i];
                        m_parked[i] = 0;
                    end
                end else if (v) begin
                    m_pend[i] = val;
                    m_parked[i] = 1;
                end
                m_tick[i] = toggles;
            end
        end
    endtask

    // Drive inputs just after an edge, clock once, update model, compare.
    task automatic cycle(input bit r, input bit e, input bit v, input int val);
        logic [31:0] vbits;
        vbits = val;
        rst = r; en = e; div_valid = v; div_value = vbits[7:0];
        @(posedge initial_clk);
        model_step(r, e, v, val);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("model_clk", i, int'(dclk[i]), int'(m_clk[i]));
            check("model_ready", i, int'(drdy[i]), int'(!m_parked[i]));
`ifdef CLK_DIVIDER_TICK_EN
            check("model_tick", i, int'(dtick[i]), int'(m_tick[i]));
`endif
        end
    endtask

    typedef struct {
        bit r; bit e; bit v; int val;
        bit eclk; bit erdy;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int rises;
        int ticks;
        int edges;
        bit prev;

        // Directed table for the DEFAULT_DIV=3 instance: startup, reload to 5
        // accepted at cnt=1, second request during PENDING ignored.
        tbl[0]  = '{1, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 1, 0, 0, 0, 1};
        tbl[2]  = '{0, 1, 1, 5, 0, 0};
        tbl[3]  = '{0, 1, 1, 1, 1, 1};
        tbl[4]  = '{0, 1, 0, 0, 1, 1};
        tbl[5]  = '{0, 1, 0, 0, 1, 1};
        tbl[6]  = '{0, 1, 0, 0, 1, 1};
        tbl[7]  = '{0, 1, 0, 0, 1, 1};
        tbl[8]  = '{0, 1, 0, 0, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 0, 1};
        tbl[10] = '{0, 1, 0, 0, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 0, 1};
        tbl[12] = '{0, 1, 0, 0, 0, 1};
        tbl[13] = '{0, 1, 0, 0, 1, 1};
        for (int k = 0; k < 14; k++) begin
            cycle(tbl[k].r, tbl[k].e, tbl[k].v, tbl[k].val);
            check("tbl_clk", 0, int'(dclk[0]), int'(tbl[k].eclk));
            check("tbl_ready", 0, int'(drdy[0]), int'(tbl[k].erdy));
        end

        // Divisor 0 behaves as 1: clk toggles every cycle after the load wrap.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 0, 0);
        check("div0_ready_before_load", 0, int'(drdy[0]), 0);
        cycle(0, 1, 0, 0);
        check("div0_ready_after_load", 0, int'(drdy[0]), 1);
        check("div0_clk_at_load", 0, int'(dclk[0]), 1);
        cycle(0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            prev = dclk[0];
            cycle(0, 1, 0, 0);
            check("div0_toggle", 0, int'(dclk[0]), int'(!prev));
        end

        // Enable freeze on the DEFAULT_DIV=4 instance at cnt=1.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0);
            check("freeze_clk", 1, int'(dclk[1]), 0);
        end
        cycle(0, 1, 0, 0);
        check("resume_clk1", 1, int'(dclk[1]), 0);
        cycle(0, 1, 0, 0);
        check("resume_clk2", 1, int'(dclk[1]), 0);
        cycle(0, 1, 0, 0);
        check("resume_clk3", 1, int'(dclk[1]), 1);

        // Reset while PENDING with clk=1 discards the parked divisor.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("prerst_clk", 0, int'(dclk[0]), 1);
        cycle(0, 1, 1, 7);
        check("prerst_ready", 0, int'(drdy[0]), 0);
        cycle(1, 1, 1, 9);
        check("rst_clk", 0, int'(dclk[0]), 0);
        check("rst_ready", 0, int'(drdy[0]), 1);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("postrst_clk2", 0, int'(dclk[0]), 0);
        cycle(0, 1, 0, 0);
        check("postrst_clk3", 0, int'(dclk[0]), 1);

        // Sustained DEFAULT_DIV=3 operation: 20 full periods in 120 cycles.
        cycle(1, 0, 0, 0);
        rises = 0;
        for (int k = 0; k < 120; k++) begin
            prev = dclk[0];
            cycle(0, 1, 0, 0);
            if (!prev && dclk[0]) rises++;
        end
        check("period6_rises", 0, rises, 20);

`ifdef CLK_DIVIDER_TICK_EN
        // DEFAULT_DIV=2: one tick per clk edge over 100 cycles.
        cycle(1, 0, 0, 0);
        ticks = 0;
        edges = 0;
        for (int k = 0; k < 100; k++) begin
            prev = dclk[2];
            cycle(0, 1, 0, 0);
            if (dclk[2] != prev) edges++;
            if (dtick[2]) ticks++;
        end
        check("tick_count", 2, ticks, 50);
        check("tick_vs_edges", 2, ticks, edges);
`else
        ticks = 0;
        edges = 0;
`endif

        // Randomised traffic against the model.
        cycle(1, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            bit r;
            bit e;
            bit v;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 3) == 0);
            cycle(r, e, v, int'($urandom_range(0, 9)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_clk_divider
